// File: rtl/kgp_arb_pkg.sv
// Shared types and default constants for the KGP-RISC unified-memory arbiter.
package kgp_arb_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_MEM_LAT    = 1;
    localparam int unsigned DEF_STARVE_MAX = 4;
    localparam int unsigned STARVE_W       = 4;

    // Owner of an in-flight read response
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } own_t;

endpackage

// File: rtl/kgp_mem_arbiter_if.sv
// Fetch, load/store and memory-port signals of the arbiter, grouped for the core/memory boundary.
interface kgp_mem_arbiter_if
    import kgp_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Core and memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/kgp_arb_resp_pipe.sv
// MEM_LAT-deep owner-tag shift register that tracks which requester each read belongs to.
module kgp_arb_resp_pipe
    import kgp_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  own_t tag_in,
    output own_t tag_out
);

    own_t stage [MEM_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                stage[i] <= OWN_NONE;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[MEM_LAT-1];

endmodule

// File: rtl/kgp_mem_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and load/store and routes read data back.
// Define KGP_ARB_RR_EN for round-robin arbitration instead of data priority with a starvation guard.
module kgp_mem_arbiter
    import kgp_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    kgp_mem_arbiter_if.slave  bus
);

    logic i_win_c;
    logic d_win_c;
    own_t tag_in;
    own_t tag_out;

`ifdef KGP_ARB_RR_EN
    logic rr_last_i;  // fetch won the most recent conflict; reset value lets data win first

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_i <= 1'b1;
        end else if (bus.i_req && bus.d_req) begin
            rr_last_i <= i_win_c;
        end
    end

    assign i_win_c = rst && bus.i_req && (!bus.d_req || !rr_last_i);
`else
    logic [STARVE_W-1:0] starve_cnt;
    logic                starved_c;

    assign starved_c = (starve_cnt == STARVE_W'(STARVE_MAX));

    // Counts fetch wait cycles, saturating at the limit that forces a fetch grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!bus.i_req || i_win_c) begin
            starve_cnt <= '0;
        end else if (!starved_c) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    assign i_win_c = rst && bus.i_req && (!bus.d_req || starved_c);
`endif

    assign d_win_c = rst && bus.d_req && !i_win_c;

    assign bus.i_gnt     = i_win_c;
    assign bus.d_gnt     = d_win_c;
    assign bus.mem_en    = i_win_c || d_win_c;
    assign bus.mem_we    = d_win_c && bus.d_we;
    assign bus.mem_addr  = i_win_c ? bus.i_addr : (d_win_c ? bus.d_addr : '0);
    assign bus.mem_wdata = d_win_c ? bus.d_wdata : '0;

    // Stores and idle cycles travel as NONE so they never raise rvalid
    assign tag_in = i_win_c              ? OWN_I :
                    (d_win_c && !bus.d_we) ? OWN_D : OWN_NONE;

    kgp_arb_resp_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_resp_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign bus.i_rvalid = (tag_out == OWN_I);
    assign bus.d_rvalid = (tag_out == OWN_D);
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;

    i_req_hold_a: assert property (@(posedge clk) disable iff (!rst)
        (bus.i_req && !bus.i_gnt) |=> bus.i_req);

    d_req_hold_a: assert property (@(posedge clk) disable iff (!rst)
        (bus.d_req && !bus.d_gnt) |=> bus.d_req);

endmodule

// File: tb/tb_kgp_mem_arbiter.sv
// Scoreboard bench: two arbiters (MEM_LAT 1 and 3) share directed stimulus; a monitor checks every read response.
module tb_kgp_mem_arbiter;
    import kgp_arb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SM = 4;

    typedef struct {
        int          k;
        own_t        own;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq [$];
    string nm [2] = '{"L1", "L3"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;

    kgp_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
    kgp_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

    kgp_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SM))
        u_l1 (.clk(clk), .rst(rst), .bus(b1.slave));
    kgp_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(SM))
        u_l3 (.clk(clk), .rst(rst), .bus(b3.slave));

    assign b1.i_req = i_req;   assign b3.i_req = i_req;
    assign b1.i_addr = i_addr; assign b3.i_addr = i_addr;
    assign b1.d_req = d_req;   assign b3.d_req = d_req;
    assign b1.d_we = d_we;     assign b3.d_we = d_we;
    assign b1.d_addr = d_addr; assign b3.d_addr = d_addr;
    assign b1.d_wdata = d_wdata; assign b3.d_wdata = d_wdata;

    logic        ig [2], dg [2], irv [2], drv [2], men [2], mwe [2];
    logic [31:0] ird [2], drd [2], maddr [2], mwdata [2], mrdata [2];

    assign ig[0] = b1.i_gnt;      assign ig[1] = b3.i_gnt;
    assign dg[0] = b1.d_gnt;      assign dg[1] = b3.d_gnt;
    assign irv[0] = b1.i_rvalid;  assign irv[1] = b3.i_rvalid;
    assign drv[0] = b1.d_rvalid;  assign drv[1] = b3.d_rvalid;
    assign ird[0] = b1.i_rdata;   assign ird[1] = b3.i_rdata;
    assign drd[0] = b1.d_rdata;   assign drd[1] = b3.d_rdata;
    assign men[0] = b1.mem_en;    assign men[1] = b3.mem_en;
    assign mwe[0] = b1.mem_we;    assign mwe[1] = b3.mem_we;
    assign maddr[0] = b1.mem_addr;   assign maddr[1] = b3.mem_addr;
    assign mwdata[0] = b1.mem_wdata; assign mwdata[1] = b3.mem_wdata;
    assign b1.mem_rdata = mrdata[0];
    assign b3.mem_rdata = mrdata[1];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h20:  return 32'h11112222;
            32'h24:  return 32'hCAFEF00D;
            32'h28:  return 32'h12345678;
            32'h30:  return 32'h33334444;
            default: return a ^ 32'hA5A50000;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Memory model: read data appears MEM_LAT cycles after a read strobe
    logic        rd_v [2][3];
    logic [31:0] rd_a [2][3];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rd_v[k][0] <= men[k] && !mwe[k];
            rd_a[k][0] <= maddr[k];
            for (int s = 1; s < 3; s++) begin
                rd_v[k][s] <= rd_v[k][s-1];
                rd_a[k][s] <= rd_a[k][s-1];
            end
        end
    end
    always_comb begin
        mrdata[0] = rd_v[0][0] ? mem_val(rd_a[0][0]) : 32'h0BAD0BAD;
        mrdata[1] = rd_v[1][2] ? mem_val(rd_a[1][2]) : 32'h0BAD0BAD;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Response monitor: pops the oldest expectation of each DUT when it raises rvalid
    always @(negedge clk) begin : mon
        int idx;
        own_t act_own;
        logic [31:0] act_data, other;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                idx = -1;
                for (int j = 0; j < sbq.size(); j++) begin
                    if (sbq[j].k == k) begin
                        idx = j;
                        break;
                    end
                end
                if (irv[k] || drv[k]) begin
                    check({nm[k], " single rvalid"}, 32'(irv[k] && drv[k]), 32'd0);
                    act_own  = irv[k] ? OWN_I : OWN_D;
                    act_data = irv[k] ? ird[k] : drd[k];
                    other    = irv[k] ? drd[k] : ird[k];
                    check({nm[k], " idle rdata zero"}, other, 32'd0);
                    if (idx < 0) begin
                        check({nm[k], " unexpected rvalid"}, 32'(act_own), 32'(OWN_NONE));
                    end else begin
                        check({nm[k], " rvalid owner"}, 32'(act_own), 32'(sbq[idx].own));
                        check({nm[k], " rdata"}, act_data, sbq[idx].data);
                        check({nm[k], " rvalid cycle"}, 32'(cyc), 32'(sbq[idx].due));
                        sbq.delete(idx);
                    end
                end else begin
                    check({nm[k], " rdata without rvalid"}, ird[k] | drd[k], 32'd0);
                    if (idx >= 0 && sbq[idx].due <= cyc) begin
                        check({nm[k], " rvalid missing"}, 32'(irv[k] || drv[k]), 32'd1);
                        sbq.delete(idx);
                    end
                end
            end
        end
    end

    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dwd, input logic eig, input logic edg);
        exp_t e;
        @(posedge clk); #1;
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check({nm[k], " i_gnt"}, 32'(ig[k]), 32'(eig));
            check({nm[k], " d_gnt"}, 32'(dg[k]), 32'(edg));
            check({nm[k], " mem_en"}, 32'(men[k]), 32'(eig || edg));
            check({nm[k], " mem_we"}, 32'(mwe[k]), 32'(edg && dwe));
            check({nm[k], " mem_addr"}, maddr[k], eig ? ia : (edg ? da : 32'd0));
            check({nm[k], " mem_wdata"}, mwdata[k], edg ? dwd : 32'd0);
            e.k = k;
            e.due = cyc + lat_of(k);
            if (eig) begin
                e.own = OWN_I; e.data = mem_val(ia); sbq.push_back(e);
            end
            if (edg && !dwe) begin
                e.own = OWN_D; e.data = mem_val(da); sbq.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check({nm[k], " ", tag, " gnt"}, 32'({ig[k], dg[k]}), 32'd0);
            check({nm[k], " ", tag, " rvalid"}, 32'({irv[k], drv[k]}), 32'd0);
            check({nm[k], " ", tag, " rdata"}, ird[k] | drd[k], 32'd0);
            check({nm[k], " ", tag, " mem ctl"}, 32'({men[k], mwe[k]}), 32'd0);
            check({nm[k], " ", tag, " mem bus"}, maddr[k] | mwdata[k], 32'd0);
        end
    endtask

    initial begin
        logic eig;
        // Reset with both requests asserted: nothing may be granted
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h77;
        repeat (3) chk_zero("reset");
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        chk_zero("reset idle");
        @(posedge clk); #1;
        rst = 1'b1;

        // Single fetch read
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(4);

        // Single store: no response
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 32'h55, 1'b0, 1'b1);
        idle(4);

        // Continuous contention
        for (int j = 0; j < 10; j++) begin
`ifdef KGP_ARB_RR_EN
            eig = (j % 2 == 1);
`else
            eig = (j % 5 == 4);
`endif
            step(1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'd0, eig, !eig);
        end
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'h30, 32'd0, 1'b0, 1'b1);

        // Alternating single-requester reads, back to back
        step(1'b1, 32'h24, 1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0,  1'b1, 1'b0, 32'h28, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0,  1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'h30, 1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0,  1'b1, 1'b0, 32'h24, 32'd0, 1'b0, 1'b1);
        idle(5);

        // Reset with reads in flight: the MEM_LAT=3 responses must vanish
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0,  1'b1, 1'b0, 32'h30, 32'd0, 1'b0, 1'b1);
        idle(1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = sbq.size() - 1; j >= 0; j--) begin
            if (sbq[j].due >= cyc) sbq.delete(j);
        end
        repeat (3) chk_zero("mid reset");
        @(posedge clk); #1;
        rst = 1'b1;
        idle(6);

        // Final read after reset recovery
        step(1'b1, 32'h28, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(5);

        check("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
